// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite master driven by a valid/ready command port, with a stall watchdog
module axi_lite_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 16
) (
  input  logic             m_axi_aclk,
  input  logic             m_axi_areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_resp,
  output logic [CNT_W-1:0] rsp_latency,
  output logic             busy,
  output logic             stalled,
  output logic [31:0]      m_axi_awaddr,
  output logic [2:0]       m_axi_awprot,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic [31:0]      m_axi_araddr,
  output logic [2:0]       m_axi_arprot,
  output logic             m_axi_arvalid,
  input  logic             m_axi_arready,
  input  logic [31:0]      m_axi_rdata,
  input  logic [1:0]       m_axi_rresp,
  input  logic             m_axi_rvalid,
  output logic             m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYCLES);
  state_t state, state_nx;
  logic acc, b_hs, r_hs, rsp_hs, inflight;
  logic [CNT_W-1:0] cnt_inc;
  assign acc      = cmd_valid & cmd_ready;
  assign b_hs     = m_axi_bvalid & m_axi_bready;
  assign r_hs     = m_axi_rvalid & m_axi_rready;
  assign rsp_hs   = rsp_valid & rsp_ready;
  assign inflight = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  assign cnt_inc  = &rsp_latency ? rsp_latency : rsp_latency + CNT_W'(1);
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset)
    if (m_axi_areset) state <= IDLE;
    else state <= state_nx;
  // a cleared valid inside WR_REQ means that channel has already handshaken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = acc ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_nx = ((~m_axi_awvalid | m_axi_awready) & (~m_axi_wvalid | m_axi_wready)) ? WR_RESP : WR_REQ;
      WR_RESP: state_nx = m_axi_bvalid ? RSP : WR_RESP;
      RD_REQ:  state_nx = m_axi_arready ? RD_RESP : RD_REQ;
      RD_RESP: state_nx = m_axi_rvalid ? RSP : RD_RESP;
      RSP:     state_nx = rsp_ready ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb cmd_ready = state == IDLE;
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset)
    if (m_axi_areset) begin
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_araddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_latency   <= '0;
      busy          <= 1'b0;
      stalled       <= 1'b0;
    end else begin
      if (acc && cmd_write) begin
        m_axi_awaddr <= cmd_addr & ~32'h3;
        m_axi_wdata  <= cmd_wdata;
        m_axi_wstrb  <= cmd_wstrb;
      end
      if (acc && !cmd_write) m_axi_araddr <= cmd_addr & ~32'h3;
      m_axi_awvalid <= (acc & cmd_write) | (m_axi_awvalid & ~m_axi_awready);
      m_axi_wvalid  <= (acc & cmd_write) | (m_axi_wvalid & ~m_axi_wready);
      m_axi_arvalid <= (acc & ~cmd_write) | (m_axi_arvalid & ~m_axi_arready);
      m_axi_bready  <= state_nx == WR_RESP;
      m_axi_rready  <= state_nx == RD_RESP;
      if (acc) begin
        busy        <= 1'b1;
        stalled     <= 1'b0;
        rsp_latency <= '0;
      end
      if (inflight) begin
        rsp_latency <= cnt_inc;
        if (cnt_inc >= TO) stalled <= 1'b1;
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
        rsp_valid <= 1'b1;
      end
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
        rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        busy      <= 1'b0;
      end
    end
endmodule
